// File: rtl/alu_pkg.sv
// Shared definitions for the ALU core: opcode encodings and pipeline chunk sizing.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of one carry chunk; callers must ensure width % stages == 0.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CW-bit ripple-carry chunk; also exposes the carry into its top bit so the
// final stage can form the signed overflow flag.
module add_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          cmsb_in
);

  logic [CW:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1])
    );
  end

  assign cout    = carry[CW];
  assign cmsb_in = carry[CW-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the leaf cell of every carry chunk.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract unit: carry chain split into STAGES chunks, valid/ready
// handshake with global stall. Define PIPELINED_ADD_SUB_SAT_EN for signed saturation.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             en;
  logic [WIDTH-1:0] b_cond;
  logic             c0;

  // Per-stage registers: skewed operands, partially completed sum, chunk carry.
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];

  // Inputs seen by each stage's chunk adder, and its results.
  logic [WIDTH-1:0]  st_a  [STAGES];
  logic [WIDTH-1:0]  st_b  [STAGES];
  logic [WIDTH-1:0]  st_s  [STAGES];
  logic              st_c  [STAGES];
  logic [WIDTH-1:0]  nx_s  [STAGES];
  logic [CW-1:0]     sum_w [STAGES];
  logic              cout_w[STAGES];
  logic              cmsb_w[STAGES];

  logic [WIDTH-1:0]  res_w;
  logic              ovf_w;
  logic [WIDTH-1:0]  res_q;
  logic              co_q;
  logic              ovf_q;
  logic              zero_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign b_cond = (op == OP_SUB) ? ~B : B;
  assign c0     = (op == OP_SUB) ? ~Cin : Cin;

  always_comb begin
    st_a[0] = A;
    st_b[0] = b_cond;
    st_s[0] = '0;
    st_c[0] = c0;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      nx_s[k]              = st_s[k];
      nx_s[k][k*CW +: CW]  = sum_w[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_chunk #(.CW(CW)) u_chunk (
      .a       (st_a[k][k*CW +: CW]),
      .b       (st_b[k][k*CW +: CW]),
      .cin     (st_c[k]),
      .s       (sum_w[k]),
      .cout    (cout_w[k]),
      .cmsb_in (cmsb_w[k])
    );
  end

  assign ovf_w = cmsb_w[LAST] ^ cout_w[LAST];

`ifdef PIPELINED_ADD_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}} >> 1;
  localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // On overflow both conditioned operands share a sign, so A's MSB gives the direction.
  always_comb begin
    res_w = nx_s[LAST];
    if (ovf_w) begin
      res_w = st_a[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign res_w = nx_s[LAST];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

  // NOTE: datapath registers carry no reset; only valid bits need a known state
  // because every output is masked by out_valid.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= st_a[k];
        b_q[k] <= st_b[k];
        s_q[k] <= nx_s[k];
        c_q[k] <= cout_w[k];
      end
      res_q  <= res_w;
      co_q   <= cout_w[LAST];
      ovf_q  <= ovf_w;
      zero_q <= (res_w == '0);
    end
  end

  assign out_valid = v_q[LAST];
  assign C         = out_valid ? res_q : '0;
  assign carry_out = out_valid & co_q;
  assign overflow  = out_valid & ovf_q;
  assign zero      = out_valid & zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench: four configurations of pipelined_add_sub share one stimulus
// stream; each is compared cycle by cycle against a behavioural pipeline model.
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [15:0] c;
    logic        co;
    logic        ovf;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic o);
    logic [16:0] m;
    logic [16:0] sum;
    logic [15:0] bb;
    logic [15:0] aa;
    logic        c0;
    res_t        r;
    m     = (17'd1 << w) - 17'd1;
    aa    = a & m[15:0];
    bb    = (o ? ~b : b) & m[15:0];
    c0    = o ? ~ci : ci;
    sum   = {1'b0, aa} + {1'b0, bb} + {16'd0, c0};
    r.c   = sum[15:0] & m[15:0];
    r.co  = sum[w];
    r.ovf = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
`ifdef PIPELINED_ADD_SUB_SAT_EN
    if (r.ovf) r.c = aa[w-1] ? (m[15:0] ^ (m[15:0] >> 1)) : (m[15:0] >> 1);
`endif
    r.z = (r.c == 16'd0);
    return r;
  endfunction

  function automatic int cfg_width(input int g);
    return (g == 1) ? 16 : 8;
  endfunction

  function automatic int cfg_stages(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W = cfg_width(g);
    localparam int S = cfg_stages(g);

    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] c;
    logic         co;
    logic         ovf;
    logic         z;
    logic [S-1:0] mv;
    res_t         md [S];
    logic         m_en;
    int           n_out = 0;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_in[W-1:0]),
      .B         (b_in[W-1:0]),
      .Cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (c),
      .carry_out (co),
      .overflow  (ovf),
      .zero      (z)
    );

    assign m_en = !mv[S-1] || out_ready;

    always @(posedge clk) begin
      if (rst) begin
        mv <= '0;
      end else if (m_en) begin
        mv[0] <= in_valid;
        md[0] <= model(W, a_in, b_in, cin, op);
        for (int i = 1; i < S; i++) begin
          mv[i] <= mv[i-1];
          md[i] <= md[i-1];
        end
      end
    end

    always @(posedge clk) begin
      if (!rst && out_valid && out_ready) n_out <= n_out + 1;
    end

    always @(negedge clk) begin
      if (checking) begin
        check($sformatf("cfg%0d out_valid", g), 32'(out_valid), 32'(mv[S-1]));
        check($sformatf("cfg%0d in_ready", g), 32'(in_ready), 32'(m_en));
        check($sformatf("cfg%0d C", g), 32'(c), mv[S-1] ? 32'(md[S-1].c) : 32'd0);
        check($sformatf("cfg%0d carry_out", g), 32'(co), 32'(mv[S-1] & md[S-1].co));
        check($sformatf("cfg%0d overflow", g), 32'(ovf), 32'(mv[S-1] & md[S-1].ovf));
        check($sformatf("cfg%0d zero", g), 32'(z), 32'(mv[S-1] & md[S-1].z));
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic o);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin      = ci;
    op       = o;
  endtask

  // Directed vectors for the 8-bit, 2-stage instance: a, b, cin, op, C, carry, ovf, zero.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       o;
    logic [7:0] c;
    logic       co;
    logic       ovf;
    logic       z;
  } vec_t;

  vec_t vecs [5];
  logic [15:0] bp_a [6];
  logic [15:0] bp_b [6];

  initial begin
    int idx;
    int n2;
    int n3;
    logic acc;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
`ifdef PIPELINED_ADD_SUB_SAT_EN
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    check("reset out_valid", 32'(g_cfg[0].out_valid), 32'd0);
    check("reset C", 32'(g_cfg[0].c), 32'd0);
    check("reset flags", {29'd0, g_cfg[0].co, g_cfg[0].ovf, g_cfg[0].z}, 32'd0);
    rst = 1'b0;

    // Reset mid-flight: two beats issued, then one reset cycle discards them.
    @(posedge clk); #1;
    drive(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post-reset in_ready", 32'(g_cfg[0].in_ready), 32'd1);
    check("post-reset out_valid", 32'(g_cfg[0].out_valid), 32'd0);
    check("post-reset C", 32'(g_cfg[0].c), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("discarded beat out_valid", 32'(g_cfg[0].out_valid), 32'd0);
    end
    repeat (6) @(posedge clk);
    #1;

    // Directed vectors, latency 2 on the 8-bit/2-stage instance.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].ci, vecs[i].o);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d early out_valid", i), 32'(g_cfg[0].out_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), 32'(g_cfg[0].out_valid), 32'd1);
      check($sformatf("vec%0d C", i), 32'(g_cfg[0].c), 32'(vecs[i].c));
      check($sformatf("vec%0d carry_out", i), 32'(g_cfg[0].co), 32'(vecs[i].co));
      check($sformatf("vec%0d overflow", i), 32'(g_cfg[0].ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d zero", i), 32'(g_cfg[0].z), 32'(vecs[i].z));
    end
    repeat (10) @(posedge clk);
    #1;

    // Backpressure on the 16-bit/4-stage instance: 6 beats, out_ready low 3 cycles.
    idx = 0;
    for (int j = 0; j < 24; j++) begin
      out_ready = !(j >= 5 && j < 8);
      if (idx < 6) drive(1'b1, bp_a[idx], bp_b[idx], idx[0], idx[1]);
      else drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      acc = in_valid && g_cfg[1].in_ready;
      if (j >= 5 && j < 8) check("stalled in_ready", 32'(g_cfg[1].in_ready), 32'd0);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    out_ready = 1'b1;
    check("backpressure beats accepted", 32'(idx), 32'd6);
    repeat (12) @(posedge clk);
    #1;

    // Throughput: 100 back-to-back beats with out_ready high.
    n2 = g_cfg[2].n_out;
    n3 = g_cfg[3].n_out;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("stages=1 results", 32'(g_cfg[2].n_out - n2), 32'd100);
    check("stages=8 results", 32'(g_cfg[3].n_out - n3), 32'd100);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
